if_stage: RTL



---
 rtl/if_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction-fetch stage of the 32-bit RISC-V pipeline.
//
// Holds the program counter and fetches one instruction at a time from
// instruction memory over a ready/valid request/response handshake (at most
// one request outstanding). It loads the IF/ID register (pipe_pc/pipe_data/
// pipe_valid) read by decode. Decode can redirect fetch with control_j/pc_j.
// A redirect flushes any wrong-path response that is in flight or buffered.
//
// Optional build macro:
//   IF_PERF_CNT_EN -- adds the fetch_count / stall_count performance
//                     counters and their output ports.
// ============================================================================
//
// state  | meaning
// -------+-------------------------------------------------------------------
// S_IDLE | first cycle after reset, no request yet
// S_REQ  | imem_req high, waiting for imem_ready
// S_WAIT | request accepted, waiting for imem_rvalid
// S_HOLD | response captured while stalled, waiting for stall to drop
// S_DROP | wrong-path request outstanding, its response is discarded
// ============================================================================

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_data,
    output logic        pipe_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    logic [2:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_pc_q,     req_pc_d;
    logic [31:0] hold_q,       hold_d;
    logic [31:0] pipe_pc_q,    pipe_pc_d;
    logic [31:0] pipe_data_q,  pipe_data_d;
    logic        pipe_valid_q, pipe_valid_d;

    // Delivery of a real instruction into IF/ID this cycle, and its payload.
    logic        deliver;
    logic [31:0] deliver_data;
    logic [31:0] jump_pc;

    // Redirect targets are forced to a word boundary.
    assign jump_pc = pc_j & ~32'd3;

    // Next-state logic: FSM transitions, PC update and IF/ID load.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_d       = hold_q;
        deliver      = 1'b0;
        deliver_data = imem_rdata;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (imem_ready) begin
                    req_pc_d = pc_q;
                    // A redirect in the acceptance cycle makes this fetch
                    // wrong-path; its response must still be drained.
                    state_d  = control_j ? S_DROP : S_WAIT;
                end
            end

            S_WAIT: begin
                if (control_j) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end

            S_HOLD: begin
                if (control_j) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_data = hold_q;
                    state_d      = S_REQ;
                end
            end

            S_DROP: begin
                // A new redirect here only retargets the PC; the one
                // outstanding response is still the one being drained.
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (control_j) begin
            pc_d = jump_pc;
        end else if (deliver) begin
            pc_d = req_pc_q + 32'd4;
        end

        pipe_pc_d    = pipe_pc_q;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = pipe_valid_q;
        if (control_j) begin
            pipe_data_d  = NOP_INSN;
            pipe_valid_d = 1'b0;
        end else if (stall) begin
            // IF/ID frozen while decode is stalled.
        end else if (deliver) begin
            pipe_pc_d    = req_pc_q;
            pipe_data_d  = deliver_data;
            pipe_valid_d = 1'b1;
        end else begin
            pipe_data_d  = NOP_INSN;
            pipe_valid_d = 1'b0;
        end
    end

    // State, PC, request address, hold buffer and IF/ID registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            hold_q       <= NOP_INSN;
            pipe_pc_q    <= RESET_PC;
            pipe_data_q  <= NOP_INSN;
            pipe_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_q       <= hold_d;
            pipe_pc_q    <= pipe_pc_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign pipe_pc    = pipe_pc_q;
    assign pipe_data  = pipe_data_q;
    assign pipe_valid = pipe_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (deliver) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (stall) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
